cdb_arbiter: RTL and testbench

//  Multi-source, multi-port successor to the single-result writeback stage.

---
 rtl/cdb_arbiter_pkg.sv | 24 ++
 rtl/cdb_src_fifo.sv | 53 +++++
 rtl/cdb_arbiter.sv | 94 +++++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the CDB arbiter: result entry layout and
// the round-robin index helper used by the grant scan.
package cdb_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 8;
    localparam int NUM_SRC = 4;
    localparam int NUM_CDB = 2;
    localparam int DEPTH   = 4;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int SRC_W   = $clog2(NUM_SRC);

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } cdb_entry_t;

    // Source index offset by step, wrapping modulo NUM_SRC.
    function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] idx,
                                                 input int step);
        return SRC_W'((int'(idx) + step) % NUM_SRC);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: DEPTH entries, naturally wrapping pointers,
// count-based full/empty, synchronous flush that empties it.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t wr_entry,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);

    cdb_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == (PTR_W+1)'(DEPTH));
    assign empty  = (count_r == (PTR_W+1)'(0));
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push & ~full & ~flush;
    assign pop_s  = pop & ~empty & ~flush;

    // Pointer and occupancy state; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            if (push_s && !pop_s)      count_r <= count_r + (PTR_W+1)'(1);
            else if (!push_s && pop_s) count_r <= count_r - (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= wr_entry;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects results from NUM_SRC FIFOs and broadcasts up to NUM_CDB of them
// per cycle on registered CDB ports, scanning sources round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    input  logic [NUM_SRC*XLEN-1:0]  src_data,
    input  logic [NUM_SRC*TAG_W-1:0] src_tag,
    output logic [NUM_CDB-1:0]       cdb_valid,
    output logic [NUM_CDB*XLEN-1:0]  cdb_result,
    output logic [NUM_CDB*TAG_W-1:0] cdb_tag
);

    logic [NUM_SRC-1:0] full_s;
    logic [NUM_SRC-1:0] empty_s;
    logic [NUM_SRC-1:0] grant_s;
    cdb_entry_t         head_s [NUM_SRC];
    logic [NUM_CDB-1:0] port_vld_s;
    logic [SRC_W-1:0]   port_src_s [NUM_CDB];
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   rr_next_s;

    assign src_ready = ~full_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        cdb_entry_t wr_s;
        assign wr_s.data = src_data[g*XLEN +: XLEN];
        assign wr_s.tag  = src_tag[g*TAG_W +: TAG_W];

        cdb_src_fifo u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .push     (src_valid[g]),
            .pop      (grant_s[g]),
            .wr_entry (wr_s),
            .full     (full_s[g]),
            .empty    (empty_s[g]),
            .head     (head_s[g])
        );
    end

    // Rotating scan from rr_ptr: the k-th non-empty source found drives port k.
    always_comb begin
        int               n_grant;
        logic             take;
        logic [SRC_W-1:0] idx;
        grant_s    = '0;
        port_vld_s = '0;
        rr_next_s  = rr_ptr_r;
        n_grant    = 0;
        take       = 1'b0;
        idx        = '0;
        for (int p = 0; p < NUM_CDB; p++) port_src_s[p] = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx          = src_inc(rr_ptr_r, k);
            take         = !empty_s[idx] && (n_grant < NUM_CDB);
            grant_s[idx] = take;
            for (int p = 0; p < NUM_CDB; p++) begin
                port_vld_s[p] = port_vld_s[p] | (take && (p == n_grant));
                port_src_s[p] = (take && (p == n_grant)) ? idx : port_src_s[p];
            end
            rr_next_s = take ? src_inc(idx, 1) : rr_next_s;
            n_grant   = n_grant + (take ? 1 : 0);
        end
    end

    // Broadcast registers; idle ports keep their last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid  <= '0;
            cdb_result <= '0;
            cdb_tag    <= '0;
            rr_ptr_r   <= '0;
        end else if (flush) begin
            cdb_valid <= '0;
            rr_ptr_r  <= '0;
        end else begin
            cdb_valid <= port_vld_s;
            rr_ptr_r  <= rr_next_s;
            for (int p = 0; p < NUM_CDB; p++) begin
                if (port_vld_s[p]) begin
                    cdb_result[p*XLEN +: XLEN]  <= head_s[port_src_s[p]].data;
                    cdb_tag[p*TAG_W +: TAG_W]   <= head_s[port_src_s[p]].tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues filled at push,
// drained by a CDB monitor, plus directed cycle checks with hand-derived values.
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   src_valid;
    logic [3:0]   src_ready;
    logic [127:0] src_data;
    logic [31:0]  src_tag;
    logic [1:0]   cdb_valid;
    logic [63:0]  cdb_result;
    logic [15:0]  cdb_tag;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q [4][$];
    logic [7:0]  drv_tag  [4];
    logic [31:0] drv_data [4];
    logic [5:0]  seq      [4];

    logic [7:0]  mon_tag;
    logic [31:0] mon_data;
    int          mon_src;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .src_tag    (src_tag),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_tag    (cdb_tag)
    );

    function automatic logic [7:0] mk_tag(input int s, input logic [5:0] q);
        return {2'(s), q};
    endfunction

    function automatic logic [31:0] mk_data(input int s, input logic [5:0] q);
        return 32'hA500_0000 | (32'(s) << 16) | 32'(q);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reload();
        for (int s = 0; s < 4; s++) begin
            drv_tag[s]  = mk_tag(s, seq[s]);
            drv_data[s] = mk_data(s, seq[s]);
        end
    endtask

    task automatic reset_seq();
        for (int s = 0; s < 4; s++) seq[s] = 6'd0;
        reload();
    endtask

    task automatic clear_q();
        for (int s = 0; s < 4; s++) exp_q[s].delete();
    endtask

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic step(input logic [3:0] vld, input logic fl);
        logic [3:0] acc;
        src_valid = vld;
        flush     = fl;
        for (int s = 0; s < 4; s++) begin
            src_tag[s*8 +: 8]   = drv_tag[s];
            src_data[s*32 +: 32] = drv_data[s];
        end
        acc = vld & src_ready;
        @(posedge clk);
        if (fl) begin
            clear_q();
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (acc[s]) begin
                    exp_q[s].push_back({drv_tag[s], drv_data[s]});
                    seq[s] = seq[s] + 6'd1;
                end
            end
        end
        reload();
        @(negedge clk);
        src_valid = 4'b0000;
        flush     = 1'b0;
    endtask

    // Monitor: every broadcast must match the head of some source's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 2; p++) begin
                if (cdb_valid[p]) begin
                    mon_tag  = cdb_tag[p*8 +: 8];
                    mon_data = cdb_result[p*32 +: 32];
                    mon_src  = -1;
                    for (int s = 0; s < 4; s++)
                        if (exp_q[s].size() > 0 && exp_q[s][0][39:32] == mon_tag) mon_src = s;
                    checks++;
                    if (mon_src < 0) begin
                        errors++;
                        $display("FAIL cdb_unexpected port %0d: got tag %h data %h expected no broadcast",
                                 p, mon_tag, mon_data);
                    end else begin
                        if (exp_q[mon_src][0][31:0] !== mon_data) begin
                            errors++;
                            $display("FAIL cdb_data port %0d tag %h: got %h expected %h",
                                     p, mon_tag, mon_data, exp_q[mon_src][0][31:0]);
                        end
                        void'(exp_q[mon_src].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = 4'b0000;
        src_data  = 128'd0;
        src_tag   = 32'd0;
        reset_seq();
        clear_q();
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(cdb_valid), 64'h0);
        chk("reset_ready", 64'(src_ready), 64'hF);
        chk("reset_result", cdb_result, 64'h0);
        chk("reset_tag", 64'(cdb_tag), 64'h0);
        rst_n = 1'b1;

        // Reset mid-burst
        repeat (3) step(4'b1111, 1'b0);
        chk("t1_pre_valid", 64'(cdb_valid), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_valid", 64'(cdb_valid), 64'h0);
        chk("t1_async_ready", 64'(src_ready), 64'hF);
        clear_q();
        reset_seq();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(4'b0000, 1'b0);
        chk("t1_post_valid", 64'(cdb_valid), 64'h0);

        // Single result, two-cycle latency
        step(4'b0000, 1'b1);
        drv_tag[2]  = 8'h15;
        drv_data[2] = 32'hDEADBEEF;
        step(4'b0100, 1'b0);
        chk("t2_c1_valid", 64'(cdb_valid), 64'h0);
        step(4'b0000, 1'b0);
        chk("t2_c2_valid", 64'(cdb_valid), 64'h1);
        chk("t2_c2_tag", 64'(cdb_tag[7:0]), 64'h15);
        chk("t2_c2_data", 64'(cdb_result[31:0]), 64'hDEADBEEF);
        step(4'b0000, 1'b0);
        chk("t2_c3_valid", 64'(cdb_valid), 64'h0);

        // All sources streaming: pair alternation, backpressure, full+pop
        step(4'b0000, 1'b1);
        reset_seq();
        for (int k = 1; k <= 14; k++) begin
            step(4'b1111, 1'b0);
            if (k >= 2) begin
                chk("t3_valid", 64'(cdb_valid), 64'h3);
                chk("t3_pair", 64'({cdb_tag[15:14], cdb_tag[7:6]}),
                    (k % 2 == 0) ? 64'h4 : 64'hE);
            end
            if (k == 6 || k == 8) chk("t3_ready_hi_full", 64'(src_ready), 64'h3);
            if (k == 7) chk("t3_ready_lo_full", 64'(src_ready), 64'hC);
        end
        repeat (12) step(4'b0000, 1'b0);
        chk("t3_drained_ready", 64'(src_ready), 64'hF);
        chk("t3_drained_valid", 64'(cdb_valid), 64'h0);

        // Round-robin start at rr_ptr=2 with sources 3 and 0 pending
        step(4'b0000, 1'b1);
        reset_seq();
        step(4'b0010, 1'b0);
        step(4'b1001, 1'b0);
        chk("t4_n2_valid", 64'(cdb_valid), 64'h1);
        chk("t4_n2_tag", 64'(cdb_tag[7:0]), 64'h40);
        step(4'b0101, 1'b0);
        chk("t4_n3_valid", 64'(cdb_valid), 64'h3);
        chk("t4_n3_tags", 64'(cdb_tag), 64'h00C0);
        step(4'b0000, 1'b0);
        chk("t4_n4_valid", 64'(cdb_valid), 64'h3);
        chk("t4_n4_tags", 64'(cdb_tag), 64'h0180);
        step(4'b0000, 1'b0);
        chk("t4_n5_valid", 64'(cdb_valid), 64'h0);

        // Flush under load with same-cycle pushes
        step(4'b0000, 1'b1);
        reset_seq();
        repeat (7) step(4'b1111, 1'b0);
        chk("t5_pre_valid", 64'(cdb_valid), 64'h3);
        chk("t5_pre_tags", 64'(cdb_tag), 64'hC282);
        step(4'b1111, 1'b1);
        chk("t5_post_valid", 64'(cdb_valid), 64'h0);
        chk("t5_post_ready", 64'(src_ready), 64'hF);
        chk("t5_post_tag_hold", 64'(cdb_tag), 64'hC282);
        repeat (4) step(4'b0000, 1'b0);
        chk("t5_idle_valid", 64'(cdb_valid), 64'h0);

        for (int s = 0; s < 4; s++) chk("final_queue_empty", 64'(exp_q[s].size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
